// File: rtl/prog_loader_mem_pkg.sv
// Shared types and default widths for the program loader and the core's fetch stage.
package prog_loader_mem_pkg;

  localparam int unsigned PLM_AW     = 8;
  localparam int unsigned PLM_DW     = 8;
  localparam int unsigned PLM_REL_CW = 4;
  localparam logic [7:0]  PLM_NOP_BYTE = 8'h00;

  typedef enum logic [1:0] {
    ST_LOAD    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } state_e;

endpackage

// File: rtl/prog_loader_mem_byte_ram.sv
// Single-port-write, synchronous read-first byte RAM; contents are not reset.
module prog_loader_mem_byte_ram #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 8
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [DW-1:0] mem_q [DEPTH];

  // Write and read on the same edge; a same-address read returns the old word.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_o <= mem_q[raddr_i];
    end
  end

endmodule

// File: rtl/prog_loader_mem.sv
// Boot loader plus program memory: streams a program in, holds the core in reset,
// then serves the core's reads and writes.
module prog_loader_mem
  import prog_loader_mem_pkg::*;
#(
  parameter int unsigned    AW             = PLM_AW,
  parameter int unsigned    DW             = PLM_DW,
  parameter int unsigned    RELEASE_CYCLES = 2,
  parameter logic [DW-1:0]  NOP_BYTE       = DW'(PLM_NOP_BYTE)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          load_valid,
  input  logic [DW-1:0] load_data,
  input  logic          load_last,
  output logic          load_ready,
  input  logic          load_start,
  output logic          core_rst_n,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic [AW:0]   prog_len
);

  localparam int unsigned RCW = PLM_REL_CW;

  state_e          state_q, state_d;
  logic [AW-1:0]   wptr_q, wptr_d;
  logic [AW:0]     prog_len_q, prog_len_d;
  logic [RCW-1:0]  rel_cnt_q, rel_cnt_d;
  logic            core_rst_n_q, core_rst_n_d;
  logic            rd_valid_q, rd_valid_d;
  logic            rd_hit_q, rd_hit_d;
  logic            rd_seen_q, rd_seen_d;

  logic            in_load, in_run, load_acc, mem_full, rd_go, wr_go;
  logic            ram_we;
  logic [AW-1:0]   ram_waddr;
  logic [DW-1:0]   ram_wdata;
  logic [DW-1:0]   ram_rdata;

  assign in_load  = (state_q == ST_LOAD);
  assign in_run   = (state_q == ST_RUN);
  assign load_acc = in_load && load_valid;
  assign mem_full = &wptr_q;
  assign rd_go    = in_run && rd_en;
  assign wr_go    = in_run && wr_en;

  assign ram_we    = load_acc || wr_go;
  assign ram_waddr = in_run ? wr_addr : wptr_q;
  assign ram_wdata = in_run ? wr_data : load_data;

  prog_loader_mem_byte_ram #(
    .AW(AW),
    .DW(DW)
  ) u_ram (
    .clk_i   (CLK),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .re_i    (rd_go),
    .raddr_i (rd_addr),
    .rdata_o (ram_rdata)
  );

  // State register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= ST_LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_LOAD: begin
        if (load_acc && (load_last || mem_full)) begin
          state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (rel_cnt_q == RCW'(RELEASE_CYCLES)) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (load_start) begin
          state_d = ST_LOAD;
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  // Datapath next values: write pointer, program length, release counter, read side.
  always_comb begin
    wptr_d       = wptr_q;
    prog_len_d   = prog_len_q;
    rel_cnt_d    = rel_cnt_q;
    core_rst_n_d = (state_d == ST_RUN);
    rd_valid_d   = rd_go;
    rd_hit_d     = rd_hit_q;
    rd_seen_d    = rd_seen_q || rd_go;

    if (rd_go) begin
      // Hit test uses the pre-write length so a same-cycle write stays read-first.
      rd_hit_d = ((AW+1)'(rd_addr) < prog_len_q);
    end

    case (state_q)
      ST_LOAD: begin
        rel_cnt_d = '0;
        if (load_acc) begin
          prog_len_d = prog_len_q + (AW+1)'(1);
          if (!mem_full) begin
            wptr_d = wptr_q + AW'(1);
          end
        end
      end
      ST_RELEASE: begin
        rel_cnt_d = rel_cnt_q + RCW'(1);
      end
      ST_RUN: begin
        if (wr_en && ((AW+1)'(wr_addr) >= prog_len_q)) begin
          prog_len_d = (AW+1)'(wr_addr) + (AW+1)'(1);
        end
        if (load_start) begin
          wptr_d     = '0;
          prog_len_d = '0;
          rel_cnt_d  = '0;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wptr_q       <= '0;
      prog_len_q   <= '0;
      rel_cnt_q    <= '0;
      core_rst_n_q <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_hit_q     <= 1'b0;
      rd_seen_q    <= 1'b0;
    end else begin
      wptr_q       <= wptr_d;
      prog_len_q   <= prog_len_d;
      rel_cnt_q    <= rel_cnt_d;
      core_rst_n_q <= core_rst_n_d;
      rd_valid_q   <= rd_valid_d;
      rd_hit_q     <= rd_hit_d;
      rd_seen_q    <= rd_seen_d;
    end
  end

  // Output drive; rd_data selects between registered sources only.
  assign load_ready = in_load;
  assign core_rst_n = core_rst_n_q;
  assign rd_valid   = rd_valid_q;
  assign prog_len   = prog_len_q;
  assign rd_data    = !rd_seen_q ? '0 : (rd_hit_q ? ram_rdata : NOP_BYTE);

endmodule

// File: tb/tb_prog_loader_mem.sv
// Directed bench for prog_loader_mem: load, release timing, reads/writes, reload, async reset.
module tb_prog_loader_mem;

  logic       CLK = 1'b0;
  logic       RST;
  logic       load_valid, load_last, load_ready, load_start;
  logic [7:0] load_data;
  logic       core_rst_n;
  logic       rd_en, rd_valid, wr_en;
  logic [7:0] rd_addr, rd_data, wr_addr, wr_data;
  logic [8:0] prog_len;

  int checks = 0;
  int errors = 0;

  prog_loader_mem #(
    .AW(8), .DW(8), .RELEASE_CYCLES(2), .NOP_BYTE(8'h00)
  ) dut (
    .CLK(CLK), .RST(RST),
    .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
    .load_ready(load_ready), .load_start(load_start), .core_rst_n(core_rst_n),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .prog_len(prog_len)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_byte(input logic [7:0] d, input logic last);
    load_valid = 1'b1;
    load_data  = d;
    load_last  = last;
    tick();
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, input logic [7:0] exp, input string tag);
    rd_en   = 1'b1;
    rd_addr = a;
    tick();
    rd_en   = 1'b0;
    check({tag, "_valid"}, 32'(rd_valid), 32'd1);
    check({tag, "_data"}, 32'(rd_data), 32'(exp));
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic wait_run(input string tag);
    int n = 0;
    while (!core_rst_n && n < 20) begin
      tick();
      n++;
    end
    check(tag, 32'(core_rst_n), 32'd1);
  endtask

  initial begin
    RST = 1'b0;
    load_valid = 1'b0; load_data = '0; load_last = 1'b0; load_start = 1'b0;
    rd_en = 1'b0; rd_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;

    // Reset values.
    #3;
    check("rst_core", 32'(core_rst_n), 32'd0);
    check("rst_ready", 32'(load_ready), 32'd1);
    check("rst_rdv", 32'(rd_valid), 32'd0);
    check("rst_rdd", 32'(rd_data), 32'd0);
    check("rst_len", 32'(prog_len), 32'd0);
    tick(); tick();
    RST = 1'b1;
    tick();

    // Three-byte load with an idle (invalid) cycle and an ignored read.
    load_byte(8'h01, 1'b0);
    check("ld1_ready", 32'(load_ready), 32'd1);
    check("ld1_len", 32'(prog_len), 32'd1);
    load_data = 8'hEE; rd_en = 1'b1; rd_addr = 8'h00;
    tick();
    rd_en = 1'b0;
    check("ld_idle_len", 32'(prog_len), 32'd1);
    check("ld_rd_ignored", 32'(rd_valid), 32'd0);
    load_byte(8'h04, 1'b0);
    load_byte(8'h0F, 1'b1);
    check("ldN_ready", 32'(load_ready), 32'd0);
    check("ldN_len", 32'(prog_len), 32'd3);
    check("ldN_core", 32'(core_rst_n), 32'd0);
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    check("rel1_core", 32'(core_rst_n), 32'd0);
    check("rel1_ready", 32'(load_ready), 32'd0);
    tick();
    check("rel2_core", 32'(core_rst_n), 32'd0);
    tick();
    check("rel3_core", 32'(core_rst_n), 32'd1);

    // RUN: load port ignored.
    load_valid = 1'b1; load_data = 8'h99;
    tick();
    load_valid = 1'b0;
    check("run_ld_ignored", 32'(prog_len), 32'd3);

    // Back-to-back reads, NOP beyond prog_len, then hold.
    rd(8'h00, 8'h01, "rd0");
    rd(8'h01, 8'h04, "rd1");
    rd(8'h05, 8'h00, "rd5_nop");
    rd(8'h02, 8'h0F, "rd2");
    tick();
    check("rd_hold_valid", 32'(rd_valid), 32'd0);
    check("rd_hold_data", 32'(rd_data), 32'h0F);

    // Same-cycle read/write is read-first.
    rd_en = 1'b1; rd_addr = 8'h01;
    wr_en = 1'b1; wr_addr = 8'h01; wr_data = 8'hAA;
    tick();
    rd_en = 1'b0; wr_en = 1'b0;
    check("rw_old", 32'(rd_data), 32'h04);
    rd(8'h01, 8'hAA, "rw_new");

    // Writes extending prog_len.
    wr(8'h08, 8'h00);
    check("wr8_len", 32'(prog_len), 32'd9);
    wr(8'h10, 8'h33);
    check("wr10_len", 32'(prog_len), 32'd17);
    wr(8'h02, 8'h77);
    check("wr_low_len", 32'(prog_len), 32'd17);
    rd(8'h08, 8'h00, "rd08");
    rd(8'h10, 8'h33, "rd10");
    rd(8'h11, 8'h00, "rd11_nop");

    // Restart and stream a full 256-byte image without load_last.
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    check("ls_core", 32'(core_rst_n), 32'd0);
    check("ls_ready", 32'(load_ready), 32'd1);
    check("ls_len", 32'(prog_len), 32'd0);
    for (int i = 0; i < 256; i++) begin
      if (i == 255) check("full_ready_before", 32'(load_ready), 32'd1);
      load_byte(8'(i) ^ 8'h5A, 1'b0);
    end
    check("full_ready_after", 32'(load_ready), 32'd0);
    check("full_len", 32'(prog_len), 32'h100);
    wait_run("full_run");
    rd(8'hFF, 8'hA5, "rdFF");
    rd(8'h05, 8'h5F, "rd05_full");

    // load_start together with a read: read completes, load restarts.
    load_start = 1'b1; rd_en = 1'b1; rd_addr = 8'h00;
    tick();
    load_start = 1'b0; rd_en = 1'b0;
    check("ls2_rdv", 32'(rd_valid), 32'd1);
    check("ls2_rdd", 32'(rd_data), 32'h5A);
    check("ls2_core", 32'(core_rst_n), 32'd0);
    check("ls2_ready", 32'(load_ready), 32'd1);
    check("ls2_len", 32'(prog_len), 32'd0);
    load_byte(8'h0C, 1'b1);
    check("reload_len", 32'(prog_len), 32'd1);
    wait_run("reload_run");
    rd(8'h05, 8'h00, "rd05_stale_nop");
    rd(8'h00, 8'h0C, "rd0_reload");

    // Asynchronous reset mid-load.
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    load_byte(8'h11, 1'b0);
    load_byte(8'h12, 1'b0);
    check("mid_len", 32'(prog_len), 32'd2);
    load_valid = 1'b1; load_data = 8'h13;
    #2;
    RST = 1'b0;
    #1;
    check("arst_len", 32'(prog_len), 32'd0);
    check("arst_ready", 32'(load_ready), 32'd1);
    check("arst_core", 32'(core_rst_n), 32'd0);
    check("arst_rdv", 32'(rd_valid), 32'd0);
    check("arst_rdd", 32'(rd_data), 32'd0);
    load_valid = 1'b0;
    tick();
    RST = 1'b1;
    tick();
    load_byte(8'h21, 1'b0);
    load_byte(8'h22, 1'b1);
    check("post_len", 32'(prog_len), 32'd2);
    wait_run("post_run");
    rd(8'h00, 8'h21, "post_rd0");
    rd(8'h01, 8'h22, "post_rd1");
    rd(8'h02, 8'h00, "post_rd2_nop");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
